// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch datapath.
// - Direction symbol bit positions ({diag,up,left}), as written by the compare cell.
// - One-hot traceback move codes.
// - Traceback FSM state encoding.
// - Score width, kept here so it matches the compare cell.
package nw_pkg;

  localparam int SYM_DIAG = 2;
  localparam int SYM_UP   = 1;
  localparam int SYM_LEFT = 0;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_DIAG = 3'b100;
  localparam logic [2:0] OP_UP   = 3'b010;
  localparam logic [2:0] OP_LEFT = 3'b001;

  localparam int SCORE_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/nw_sym_decode.sv
// Priority decode of a 3-bit direction symbol into a one-hot move.
// Ports:
//   sym     in  3  symbol {diag,up,left}
//   op      out 3  one-hot move; DIAG beats UP beats LEFT when several bits are set
//   invalid out 1  symbol 000 (no predecessor recorded)
module nw_sym_decode
  import nw_pkg::*;
(
  input  logic [2:0] sym,
  output logic [2:0] op,
  output logic       invalid
);

  always_comb begin
    op      = OP_NONE;
    invalid = 1'b0;
    if (sym[SYM_DIAG]) begin
      op = OP_DIAG;
    end else if (sym[SYM_UP]) begin
      op = OP_UP;
    end else if (sym[SYM_LEFT]) begin
      op = OP_LEFT;
    end else begin
      invalid = 1'b1;
    end
  end

endmodule

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the direction matrix from (N,M) back to
// (0,0) through a synchronous-read RAM and streams one move per step, end first.
//
// Optional feature macro: TRACEBACK_STATS_EN adds per-move-type counters.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin a traceback (only honoured in IDLE)
//   busy         walk in progress (ISSUE/CAPTURE/EMIT)
//   done         one-cycle pulse at the end of a walk (normal or error)
//   err          sticky: a 000 symbol was read; cleared by the next start
//   dir_rd_en    direction-RAM read strobe
//   dir_addr     row-major address i*(M+1)+j
//   dir_data     symbol returned the cycle after dir_rd_en
//   op_valid     move available
//   op_ready     consumer accepts the move
//   op, op_i, op_j  one-hot move and the cell it leaves
//   dbg_state    current FSM state (nw_pkg::state_t encoding)
//   n_diag, n_up, n_left  (TRACEBACK_STATS_EN only) accepted moves per type
//
// Stream handshake: a move transfers on every rising edge where
// op_valid && op_ready; while op_valid is high and op_ready is low, op, op_i
// and op_j hold their values and op_valid stays high.
module nw_traceback
  import nw_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 8,
  localparam int IW = $clog2(N + 1),
  localparam int JW = $clog2(M + 1),
  localparam int AW = $clog2((N + 1) * (M + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          dir_rd_en,
  output logic [AW-1:0] dir_addr,
  input  logic [2:0]    dir_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [2:0]    op,
  output logic [IW-1:0] op_i,
  output logic [JW-1:0] op_j,
  output logic [2:0]    dbg_state
`ifdef TRACEBACK_STATS_EN
  ,
  output logic [$clog2(N+M+1)-1:0] n_diag,
  output logic [$clog2(N+M+1)-1:0] n_up,
  output logic [$clog2(N+M+1)-1:0] n_left
`endif
);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic          err_q, err_d;
  logic [2:0]    op_q, op_d;

  logic [2:0]    dec_op;
  logic          dec_invalid;
  logic [AW-1:0] addr_calc;
  logic          handshake;

  nw_sym_decode u_dec (
    .sym     (dir_data),
    .op      (dec_op),
    .invalid (dec_invalid)
  );

  // Full-width unsigned row-major address; i and j are never below zero.
  assign addr_calc = AW'(i_q) * AW'(M + 1) + AW'(j_q);
  assign handshake = (state_q == ST_EMIT) && op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    err_d     = err_q;
    op_d      = op_q;
    dir_rd_en = 1'b0;
    dir_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = IW'(N);
          j_d     = JW'(M);
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // On row 0 or column 0 the only legal move is forced, so no read.
        if (i_q != '0 && j_q != '0) begin
          dir_rd_en = 1'b1;
          dir_addr  = addr_calc;
          state_d   = ST_CAPTURE;
        end else if (i_q == '0) begin
          op_d    = OP_LEFT;
          state_d = ST_EMIT;
        end else begin
          op_d    = OP_UP;
          state_d = ST_EMIT;
        end
      end
      ST_CAPTURE: begin
        if (dec_invalid) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          op_d    = dec_op;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (op_ready) begin
          if (op_q[SYM_DIAG]) begin
            i_d = i_q - IW'(1);
            j_d = j_q - JW'(1);
          end else if (op_q[SYM_UP]) begin
            i_d = i_q - IW'(1);
          end else begin
            j_d = j_q - JW'(1);
          end
          if (i_d == '0 && j_d == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE) || (state_q == ST_EMIT);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign op_valid  = (state_q == ST_EMIT);
  assign op        = op_q;
  assign op_i      = i_q;
  assign op_j      = j_q;
  assign dbg_state = state_q;

`ifdef TRACEBACK_STATS_EN
  localparam int CW = $clog2(N + M + 1);

  logic [CW-1:0] n_diag_q, n_up_q, n_left_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_diag_q <= '0;
      n_up_q   <= '0;
      n_left_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      n_diag_q <= '0;
      n_up_q   <= '0;
      n_left_q <= '0;
    end else if (handshake) begin
      if (op_q[SYM_DIAG]) n_diag_q <= n_diag_q + CW'(1);
      if (op_q[SYM_UP])   n_up_q   <= n_up_q + CW'(1);
      if (op_q[SYM_LEFT]) n_left_q <= n_left_q + CW'(1);
    end
  end

  assign n_diag = n_diag_q;
  assign n_up   = n_up_q;
  assign n_left = n_left_q;
`else
  logic unused_hs;
  assign unused_hs = handshake;
`endif

endmodule

// File: tb/tb_nw_traceback.sv
// Bench for nw_traceback: two instances (N=M=2 and N=2,M=3), each with its own
// direction-RAM model. Table of directed walks plus hand-written sequences for
// backpressure, mid-run reset and start-while-busy.
module tb_nw_traceback;
  import nw_pkg::*;

  localparam int W = 7;  // {op[2:0], i[1:0], j[1:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_s    [2];
  logic       op_ready_s [2];
  logic       busy_s     [2];
  logic       done_s     [2];
  logic       err_s      [2];
  logic       rd_en_s    [2];
  logic [3:0] addr_s     [2];
  logic [2:0] rd_data_s  [2];
  logic       op_valid_s [2];
  logic [2:0] op_s       [2];
  logic [1:0] op_i_s     [2];
  logic [1:0] op_j_s     [2];
  logic [2:0] state_s    [2];
`ifdef TRACEBACK_STATS_EN
  logic [2:0] n_diag_s [2];
  logic [2:0] n_up_s   [2];
  logic [2:0] n_left_s [2];
`endif

  logic [2:0] ram [2][16];

  nw_traceback #(.N(2), .M(2)) u_dut22 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .err(err_s[0]), .dir_rd_en(rd_en_s[0]), .dir_addr(addr_s[0]), .dir_data(rd_data_s[0]),
    .op_valid(op_valid_s[0]), .op_ready(op_ready_s[0]), .op(op_s[0]), .op_i(op_i_s[0]),
    .op_j(op_j_s[0]), .dbg_state(state_s[0])
`ifdef TRACEBACK_STATS_EN
    , .n_diag(n_diag_s[0]), .n_up(n_up_s[0]), .n_left(n_left_s[0])
`endif
  );

  nw_traceback #(.N(2), .M(3)) u_dut23 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .err(err_s[1]), .dir_rd_en(rd_en_s[1]), .dir_addr(addr_s[1]), .dir_data(rd_data_s[1]),
    .op_valid(op_valid_s[1]), .op_ready(op_ready_s[1]), .op(op_s[1]), .op_i(op_i_s[1]),
    .op_j(op_j_s[1]), .dbg_state(state_s[1])
`ifdef TRACEBACK_STATS_EN
    , .n_diag(n_diag_s[1]), .n_up(n_up_s[1]), .n_left(n_left_s[1])
`endif
  );

  // Synchronous-read direction RAM models.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en_s[k]) rd_data_s[k] <= ram[k][addr_s[k]];
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int              k;
    int              nw;
    logic [2:0][3:0] waddr;
    logic [2:0][2:0] wval;
    int              nops;
    logic [5:0][W-1:0] exp_ops;
    int              reads;
    logic            exp_err;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic set_vec(input int v, input int k, input int reads, input logic e);
    vecs[v].k       = k;
    vecs[v].nw      = 0;
    vecs[v].waddr   = '0;
    vecs[v].wval    = '0;
    vecs[v].nops    = 0;
    vecs[v].exp_ops = '0;
    vecs[v].reads   = reads;
    vecs[v].exp_err = e;
  endtask

  task automatic add_w(input int v, input logic [3:0] a, input logic [2:0] d);
    vecs[v].waddr[vecs[v].nw] = a;
    vecs[v].wval[vecs[v].nw]  = d;
    vecs[v].nw++;
  endtask

  task automatic add_op(input int v, input logic [2:0] o, input logic [1:0] i, input logic [1:0] j);
    vecs[v].exp_ops[vecs[v].nops] = {o, i, j};
    vecs[v].nops++;
  endtask

  task automatic load_ram(input int v);
    int k;
    k = vecs[v].k;
    for (int a = 0; a < 16; a++) ram[k][a] = 3'b000;
    for (int w = 0; w < vecs[v].nw; w++) ram[k][vecs[v].waddr[w]] = vecs[v].wval[w];
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int k, reads, nops, got_done;
    logic [W-1:0] exp_v;
    int ed, eu, el;
    k = vecs[v].k;
    load_ram(v);
    exp_q.delete();
    ed = 0; eu = 0; el = 0;
    for (int n = 0; n < vecs[v].nops; n++) begin
      exp_q.push_back(vecs[v].exp_ops[n]);
      if (vecs[v].exp_ops[n][6:4] == OP_DIAG) ed++;
      if (vecs[v].exp_ops[n][6:4] == OP_UP)   eu++;
      if (vecs[v].exp_ops[n][6:4] == OP_LEFT) el++;
    end
    op_ready_s[k] = 1'b1;
    pulse_start(k);
    check($sformatf("v%0d_busy_after_start", v), busy_s[k], 1);
    check($sformatf("v%0d_err_cleared", v), err_s[k], 0);
    reads = 0; nops = 0; got_done = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (rd_en_s[k]) reads++;
      if (op_valid_s[k] && op_ready_s[k]) begin
        nops++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
        check($sformatf("v%0d_move%0d", v, nops), {op_s[k], op_i_s[k], op_j_s[k]}, exp_v);
      end
      if (done_s[k]) begin
        got_done = 1;
        check($sformatf("v%0d_err_at_done", v), err_s[k], vecs[v].exp_err);
        check($sformatf("v%0d_busy_at_done", v), busy_s[k], 0);
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_done_seen", v), got_done, 1);
    check($sformatf("v%0d_move_count", v), nops, vecs[v].nops);
    check($sformatf("v%0d_ram_reads", v), reads, vecs[v].reads);
`ifdef TRACEBACK_STATS_EN
    check($sformatf("v%0d_n_diag", v), n_diag_s[k], ed);
    check($sformatf("v%0d_n_up", v), n_up_s[k], eu);
    check($sformatf("v%0d_n_left", v), n_left_s[k], el);
`endif
    @(negedge clk);
    check($sformatf("v%0d_done_one_cycle", v), done_s[k], 0);
    check($sformatf("v%0d_err_sticky", v), err_s[k], vecs[v].exp_err);
    check($sformatf("v%0d_idle", v), state_s[k], ST_IDLE);
  endtask

  task automatic check_reset_outputs(input string tag, input int k);
    check({tag, "_busy"}, busy_s[k], 0);
    check({tag, "_done"}, done_s[k], 0);
    check({tag, "_err"}, err_s[k], 0);
    check({tag, "_rd_en"}, rd_en_s[k], 0);
    check({tag, "_addr"}, addr_s[k], 0);
    check({tag, "_op_valid"}, op_valid_s[k], 0);
    check({tag, "_op"}, {op_s[k], op_i_s[k], op_j_s[k]}, 0);
    check({tag, "_state"}, state_s[k], ST_IDLE);
  endtask

  // ---------------- test ----------------
  initial begin
    int seen, ndone, nops;

    // Table: N=M=2 addresses are i*3+j, N=2,M=3 addresses are i*4+j.
    set_vec(0, 0, 2, 1'b0);
    add_w(0, 4'd8, 3'b100); add_w(0, 4'd4, 3'b100);
    add_op(0, OP_DIAG, 2'd2, 2'd2); add_op(0, OP_DIAG, 2'd1, 2'd1);

    set_vec(1, 1, 3, 1'b0);
    add_w(1, 4'd11, 3'b001); add_w(1, 4'd10, 3'b100); add_w(1, 4'd5, 3'b100);
    add_op(1, OP_LEFT, 2'd2, 2'd3); add_op(1, OP_DIAG, 2'd2, 2'd2); add_op(1, OP_DIAG, 2'd1, 2'd1);

    set_vec(2, 0, 2, 1'b0);
    add_w(2, 4'd8, 3'b111); add_w(2, 4'd4, 3'b100);
    add_op(2, OP_DIAG, 2'd2, 2'd2); add_op(2, OP_DIAG, 2'd1, 2'd1);

    set_vec(3, 0, 3, 1'b0);
    add_w(3, 4'd8, 3'b011); add_w(3, 4'd5, 3'b001); add_w(3, 4'd4, 3'b100);
    add_op(3, OP_UP, 2'd2, 2'd2); add_op(3, OP_LEFT, 2'd1, 2'd2); add_op(3, OP_DIAG, 2'd1, 2'd1);

    set_vec(4, 0, 1, 1'b1);
    add_w(4, 4'd8, 3'b000);

    set_vec(5, 0, 2, 1'b0);
    add_w(5, 4'd8, 3'b010); add_w(5, 4'd5, 3'b100);
    add_op(5, OP_UP, 2'd2, 2'd2); add_op(5, OP_DIAG, 2'd1, 2'd2); add_op(5, OP_LEFT, 2'd0, 2'd1);

    set_vec(6, 1, 2, 1'b0);
    add_w(6, 4'd11, 3'b010); add_w(6, 4'd7, 3'b010);
    add_op(6, OP_UP, 2'd2, 2'd3); add_op(6, OP_UP, 2'd1, 2'd3); add_op(6, OP_LEFT, 2'd0, 2'd3);
    add_op(6, OP_LEFT, 2'd0, 2'd2); add_op(6, OP_LEFT, 2'd0, 2'd1);

    // Reset.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k]    = 1'b0;
      op_ready_s[k] = 1'b1;
      for (int a = 0; a < 16; a++) ram[k][a] = 3'b000;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst22", 0);
    check_reset_outputs("rst23", 1);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      run_vec(v);
      @(negedge clk);
    end

    // Backpressure: hold op_ready low for 5 cycles in EMIT.
    load_ram(0);
    op_ready_s[0] = 1'b0;
    pulse_start(0);
    seen = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (op_valid_s[0]) seen = 1;
      else @(negedge clk);
    end
    check("bp_valid_reached", seen, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_held", op_valid_s[0], 1);
      check("bp_move_stable", {op_s[0], op_i_s[0], op_j_s[0]}, {OP_DIAG, 2'd2, 2'd2});
      @(negedge clk);
    end
    op_ready_s[0] = 1'b1;
    @(negedge clk);
    check("bp_index_after_accept", {op_i_s[0], op_j_s[0]}, {2'd1, 2'd1});
    ndone = 0;
    for (int cyc = 0; cyc < 20 && ndone == 0; cyc++) begin
      if (done_s[0]) ndone++;
      else @(negedge clk);
    end
    check("bp_done", ndone, 1);
    repeat (2) @(negedge clk);

    // Start pulses while busy are ignored.
    load_ram(1);
    op_ready_s[1] = 1'b1;
    pulse_start(1);
    nops = 0; ndone = 0;
    for (int cyc = 0; cyc < 60 && ndone == 0; cyc++) begin
      if (op_valid_s[1] && op_ready_s[1]) nops++;
      if (done_s[1]) ndone++;
      start_s[1] = busy_s[1];
      @(negedge clk);
    end
    start_s[1] = 1'b0;
    check("busy_start_done", ndone, 1);
    check("busy_start_moves", nops, 3);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy_s[1] || rd_en_s[1]) seen = 1;
      @(negedge clk);
    end
    check("busy_start_no_restart", seen, 0);

    // Reset in CAPTURE aborts at once without a done pulse.
    load_ram(0);
    pulse_start(0);
    seen = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (rd_en_s[0]) seen = 1;
      else @(negedge clk);
    end
    check("mid_rst_read_seen", seen, 1);
    @(negedge clk);
    check("mid_rst_in_capture", state_s[0], ST_CAPTURE);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst", 0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      if (done_s[0] || busy_s[0]) ndone++;
      @(negedge clk);
    end
    check("mid_rst_quiet", ndone, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
